// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display fed by three BCD digits.
// Optional build macro LEAD_ZERO_BLANK_EN suppresses leading zeros on the hundreds and tens digits.
module bcd_7seg_scan #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] cen,
   input  logic [3:0] dez,
   input  logic [3:0] und,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int          CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [3:0]    dig_c, dig_d, dig_u;
   logic [CW-1:0] div_cnt;
   logic [1:0]    idx;
   logic          tick;
   logic          blank;
   logic [3:0]    an_next;
   logic [6:0]    seg_next;

   // Active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b0111111;
      endcase
   endfunction

   assign tick  = (div_cnt == LAST);
   assign blank = (int'(div_cnt) < BLANK_CYC);
   assign dp    = 1'b1;

   always_comb begin
      an_next  = 4'b1111;
      seg_next = 7'b1111111;
      case (idx)
         2'd0: begin
            seg_next = seg_decode(dig_u);
            if (!blank) an_next = 4'b1110;
         end
         2'd1: begin
            seg_next = seg_decode(dig_d);
`ifdef LEAD_ZERO_BLANK_EN
            if (!blank && (dig_c != 4'd0 || dig_d != 4'd0)) an_next = 4'b1101;
`else
            if (!blank) an_next = 4'b1101;
`endif
         end
         2'd2: begin
            seg_next = seg_decode(dig_c);
`ifdef LEAD_ZERO_BLANK_EN
            if (!blank && dig_c != 4'd0) an_next = 4'b1011;
`else
            if (!blank) an_next = 4'b1011;
`endif
         end
         default: begin
            an_next  = 4'b1111;
            seg_next = 7'b1111111;
         end
      endcase
   end

   // load has no handshake: sampled every edge, so holding it high makes the regs track the inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         dig_c      <= 4'd0;
         dig_d      <= 4'd0;
         dig_u      <= 4'd0;
         div_cnt    <= '0;
         idx        <= 2'd0;
         an         <= 4'b1111;
         seg        <= 7'b1111111;
         frame_tick <= 1'b0;
      end else begin
         if (load) begin
            dig_c <= cen;
            dig_d <= dez;
            dig_u <= und;
         end
         div_cnt <= tick ? '0 : div_cnt + CW'(1);
         if (idx == 2'd3)
            idx <= 2'd0;
         else if (tick)
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         frame_tick <= tick && (idx == 2'd2);
         an         <= an_next;
         seg        <= seg_next;
      end
   end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan with CLK_DIV=8, BLANK_CYC=2; expectations follow LEAD_ZERO_BLANK_EN.
module tb_bcd_7seg_scan;

   localparam int CLK_DIV   = 8;
   localparam int BLANK_CYC = 2;

   logic       clk = 1'b0;
   logic       rst, load;
   logic [3:0] cen, dez, und;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp, frame_tick;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_7seg_scan #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk(clk), .rst(rst), .load(load), .cen(cen), .dez(dez), .und(und),
      .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
   );

   typedef struct {
      logic [3:0] cen, dez, und;
      logic [6:0] seg_h, seg_t, seg_u;
      logic [3:0] an_t_lzb, an_h_lzb;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst  = 1'b1;
      load = 1'b0;
      repeat (n) step();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_an, an_t, an_h;
      logic [6:0] exp_seg;
      int         slot, ph;

      vecs[0] = '{4'd1, 4'd2, 4'd3, 7'b1111001, 7'b0100100, 7'b0110000, 4'b1101, 4'b1011};
      vecs[1] = '{4'hA, 4'hF, 4'd9, 7'b0111111, 7'b0111111, 7'b0010000, 4'b1101, 4'b1011};
      vecs[2] = '{4'd0, 4'd0, 4'd7, 7'b1000000, 7'b1000000, 7'b1111000, 4'b1111, 4'b1111};
      vecs[3] = '{4'd0, 4'd5, 4'd0, 7'b1000000, 7'b0010010, 7'b1000000, 4'b1101, 4'b1111};
      vecs[4] = '{4'd8, 4'd0, 4'd6, 7'b0000000, 7'b1000000, 7'b0000010, 4'b1101, 4'b1011};
      vecs[5] = '{4'd4, 4'd7, 4'd0, 7'b0011001, 7'b1111000, 7'b1000000, 4'b1101, 4'b1011};
      vecs[6] = '{4'd0, 4'd0, 4'd0, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111, 4'b1111};

      rst  = 1'b1;
      load = 1'b0;
      cen  = 4'd0;
      dez  = 4'd0;
      und  = 4'd0;
      @(negedge clk);

      // Reset state, then first enabled digit on the third edge after release.
      do_reset(3);
      check("reset_an", {4'd0, an}, {4'd0, 4'b1111});
      check("reset_seg", {1'b0, seg}, {1'b0, 7'b1111111});
      check("reset_dp", {7'd0, dp}, 8'd1);
      check("reset_ft", {7'd0, frame_tick}, 8'd0);
      step();
      check("rel_e0_an", {4'd0, an}, {4'd0, 4'b1111});
      step();
      check("rel_e1_an", {4'd0, an}, {4'd0, 4'b1111});
      step();
      check("rel_e2_an", {4'd0, an}, {4'd0, 4'b1110});
      check("rel_e2_seg", {1'b0, seg}, {1'b0, 7'b1000000});

      // Table: load at edge 0, then check one full frame plus the wrap.
      for (int v = 0; v < 7; v++) begin
`ifdef LEAD_ZERO_BLANK_EN
         an_t = vecs[v].an_t_lzb;
         an_h = vecs[v].an_h_lzb;
`else
         an_t = 4'b1101;
         an_h = 4'b1011;
`endif
         do_reset(2);
         cen  = vecs[v].cen;
         dez  = vecs[v].dez;
         und  = vecs[v].und;
         load = 1'b1;
         for (int k = 0; k < 26; k++) begin
            step();
            if (k == 0) begin
               load = 1'b0;
            end else begin
               slot = (k / CLK_DIV) % 3;
               ph   = k % CLK_DIV;
               case (slot)
                  0:       begin exp_an = 4'b1110; exp_seg = vecs[v].seg_u; end
                  1:       begin exp_an = an_t;    exp_seg = vecs[v].seg_t; end
                  default: begin exp_an = an_h;    exp_seg = vecs[v].seg_h; end
               endcase
               if (ph < BLANK_CYC) exp_an = 4'b1111;
               check($sformatf("v%0d_k%0d_an", v, k), {4'd0, an}, {4'd0, exp_an});
               check($sformatf("v%0d_k%0d_seg", v, k), {1'b0, seg}, {1'b0, exp_seg});
               check($sformatf("v%0d_k%0d_ft", v, k), {7'd0, frame_tick}, {7'd0, (k == 23)});
               check($sformatf("v%0d_k%0d_dp", v, k), {7'd0, dp}, 8'd1);
            end
         end
      end

      // Load coinciding with the tick at div_cnt==7.
      do_reset(2);
      for (int k = 0; k < 7; k++) step();
      cen  = 4'd9;
      dez  = 4'd9;
      und  = 4'd9;
      load = 1'b1;
      step();
      load = 1'b0;
      check("lot_e7_an", {4'd0, an}, {4'd0, 4'b1110});
      check("lot_e7_seg", {1'b0, seg}, {1'b0, 7'b1000000});
      step();
      check("lot_e8_an", {4'd0, an}, {4'd0, 4'b1111});
      step();
      check("lot_e9_an", {4'd0, an}, {4'd0, 4'b1111});
      step();
      check("lot_e10_an", {4'd0, an}, {4'd0, 4'b1101});
      check("lot_e10_seg", {1'b0, seg}, {1'b0, 7'b0010000});

      // Reset at div_cnt=5, idx=2 with a simultaneous load.
      do_reset(2);
      cen  = 4'd1;
      dez  = 4'd2;
      und  = 4'd3;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int k = 1; k < 21; k++) step();
      check("mid_pre_an", {4'd0, an}, {4'd0, an_h_exp(4'd1)});
      check("mid_pre_seg", {1'b0, seg}, {1'b0, 7'b1111001});
      cen  = 4'd9;
      dez  = 4'd9;
      und  = 4'd9;
      load = 1'b1;
      rst  = 1'b1;
      step();
      rst  = 1'b0;
      load = 1'b0;
      check("mid_rst_an", {4'd0, an}, {4'd0, 4'b1111});
      check("mid_rst_seg", {1'b0, seg}, {1'b0, 7'b1111111});
      check("mid_rst_ft", {7'd0, frame_tick}, 8'd0);
      step();
      check("mid_e0_an", {4'd0, an}, {4'd0, 4'b1111});
      check("mid_e0_seg", {1'b0, seg}, {1'b0, 7'b1000000});
      step();
      check("mid_e1_an", {4'd0, an}, {4'd0, 4'b1111});
      step();
      check("mid_e2_an", {4'd0, an}, {4'd0, 4'b1110});
      check("mid_e2_seg", {1'b0, seg}, {1'b0, 7'b1000000});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hundreds anode when shown: only suppressed by leading-zero blanking on a zero digit.
   function automatic logic [3:0] an_h_exp(input logic [3:0] c);
`ifdef LEAD_ZERO_BLANK_EN
      an_h_exp = (c == 4'd0) ? 4'b1111 : 4'b1011;
`else
      an_h_exp = (c == 4'd0) ? 4'b1011 : 4'b1011;
`endif
   endfunction

endmodule
